// File: rtl/aes_key_expand_param_if.sv
// Key-expander request/readback bundle.
// Slave side is the expander, master side is the requester.
interface aes_key_expand_param_if;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key;
   logic         busy;
   logic         key_expanded;
   logic         keys_valid;
   logic         err;
   logic [3:0]   rd_round;
   logic [127:0] rd_key;

   modport slave (
      input  start, key_len, key, rd_round,
      output busy, key_expanded, keys_valid, err, rd_key
   );

   modport master (
      output start, key_len, key, rd_round,
      input  busy, key_expanded, keys_valid, err, rd_key
   );
endinterface

// File: rtl/aes_key_expand_param.sv
// Word-serial AES-128/192/256 key schedule.
// One schedule word per cycle into a round-key store.
module aes_key_expand_param #(
   parameter int NK_MAX = 8
) (
   input  logic clk,
   input  logic n_rst,
   aes_key_expand_param_if.slave bus
);

   localparam int WORDS_MAX = 4 * (NK_MAX + 7);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_GEN,
      S_DONE
   } state_t;

   state_t       r_state;
   state_t       w_next;

   logic [31:0]  r_store [WORDS_MAX];
   logic [31:0]  r_win   [8];
   logic [255:0] r_key;
   logic [7:0]   r_rcon;
   logic [3:0]   r_nk;
   logic [3:0]   r_nr;
   logic [5:0]   r_i;
   logic [2:0]   r_imod;
   logic         r_kexp;
   logic         r_valid;
   logic         r_err;

   logic [3:0]   w_req_nk;
   logic         w_legal;
   logic         w_open;
   logic         w_accept;
   logic         w_reject;
   logic [5:0]   w_last;
   logic [31:0]  w_kw [8];
   logic [31:0]  w_prev;
   logic [31:0]  w_old;
   logic         w_rot;
   logic         w_sub;
   logic [31:0]  w_sw_in;
   logic [31:0]  w_sw;
   logic [31:0]  w_temp;
   logic [31:0]  w_new;
   logic [7:0]   w_xt;
   logic [5:0]   w_idx;
   logic [127:0] w_rd;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] p;
      p = {~b, 3'b000};
      return SBOX[p +: 8];
   endfunction

   // Decode the requested key length and classify a start request.
   always_comb begin
      unique case (bus.key_len)
         2'd0:    w_req_nk = 4'd4;
         2'd1:    w_req_nk = 4'd6;
         default: w_req_nk = 4'd8;
      endcase
      w_legal  = (bus.key_len != 2'd3) && (int'(w_req_nk) <= NK_MAX);
      w_open   = (r_state == S_IDLE) || (r_state == S_DONE);
      w_accept = w_open && bus.start && w_legal;
      w_reject = w_open && bus.start && !w_legal;
      w_last   = {r_nr, 2'b11};
   end

   // Schedule datapath: one new word from the sliding window.
   always_comb begin
      for (int j = 0; j < 8; j++) begin
         w_kw[j] = r_key[255 - 32*j -: 32];
      end
      w_prev = r_win[7];
      unique case (r_nk)
         4'd4:    w_old = r_win[4];
         4'd6:    w_old = r_win[2];
         default: w_old = r_win[0];
      endcase
      w_rot   = (r_imod == 3'd0);
      w_sub   = (r_nk == 4'd8) && (r_imod == 3'd4);
      w_sw_in = w_rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;
      w_sw    = {sbox(w_sw_in[31:24]), sbox(w_sw_in[23:16]),
                 sbox(w_sw_in[15:8]),  sbox(w_sw_in[7:0])};
      if (w_rot)
         w_temp = w_sw ^ {r_rcon, 24'h0};
      else if (w_sub)
         w_temp = w_sw;
      else
         w_temp = w_prev;
      w_new = w_old ^ w_temp;
      w_xt  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic and busy flag.
   always_comb begin
      w_next   = r_state;
      bus.busy = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept)
               w_next = S_LOAD;
         end
         S_LOAD: begin
            bus.busy = 1'b1;
            w_next   = S_GEN;
         end
         S_GEN: begin
            bus.busy = 1'b1;
            if (r_i == w_last)
               w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Key latch, load, word generation and status pulses.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int j = 0; j < WORDS_MAX; j++)
            r_store[j] <= '0;
         for (int k = 0; k < 8; k++)
            r_win[k] <= '0;
         r_key   <= '0;
         r_rcon  <= '0;
         r_nk    <= '0;
         r_nr    <= '0;
         r_i     <= '0;
         r_imod  <= '0;
         r_kexp  <= 1'b0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_kexp <= 1'b0;
         r_err  <= w_reject;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_nk    <= w_req_nk;
                  r_nr    <= w_req_nk + 4'd6;
                  r_key   <= bus.key;
                  r_valid <= 1'b0;
               end
            end
            S_LOAD: begin
               for (int j = 0; j < 8; j++) begin
                  if (j < int'(r_nk))
                     r_store[j] <= w_kw[j];
               end
               for (int k = 0; k < 8; k++) begin
                  if ((k + int'(r_nk)) >= 8)
                     r_win[k] <= w_kw[3'(k) + r_nk[2:0]];
               end
               r_i    <= {2'b00, r_nk};
               r_imod <= 3'd0;
               r_rcon <= 8'h01;
            end
            S_GEN: begin
               r_store[r_i] <= w_new;
               for (int k = 0; k < 7; k++)
                  r_win[k] <= r_win[k+1];
               r_win[7] <= w_new;
               r_i      <= r_i + 6'd1;
               if ({1'b0, r_imod} == r_nk - 4'd1)
                  r_imod <= 3'd0;
               else
                  r_imod <= r_imod + 3'd1;
               if (w_rot)
                  r_rcon <= w_xt;
               if (r_i == w_last) begin
                  r_kexp  <= 1'b1;
                  r_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Round-indexed readback; rounds past Nr read as zero.
   always_comb begin
      w_rd  = '0;
      w_idx = '0;
      if (bus.rd_round <= r_nr) begin
         for (int q = 0; q < 4; q++) begin
            w_idx = {bus.rd_round, 2'(q)};
            if (int'(w_idx) < WORDS_MAX)
               w_rd[127 - 32*q -: 32] = r_store[w_idx];
         end
      end
   end

   assign bus.rd_key       = w_rd;
   assign bus.key_expanded = r_kexp;
   assign bus.keys_valid   = r_valid;
   assign bus.err          = r_err;

endmodule

// File: doc/aes_key_expand_param.md
Name: aes_key_expand_param

Overview:
Word-serial AES key schedule supporting AES-128, AES-192 and AES-256, selected per operation by key_len. It generates one 32-bit schedule word per cycle into an internal round-key store of up to 60 words. The store is read by the cipher datapath through a combinational round-indexed port. It generalises the fixed 128-bit, 1408-bit-output expander to all FIPS-197 key lengths, with a start/done handshake and error reporting.

Parameters:
NK_MAX, 8, largest supported key length in 32-bit words; legal values 4, 6, 8; key_len values needing Nk > NK_MAX are illegal
WORDS_MAX, 4*(NK_MAX+7), depth of the round-key store in words; derived, not overridden

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
start  in  1  begin expansion; sampled only in IDLE or DONE
key_len  in  2  0=128-bit, 1=192-bit, 2=256-bit, 3=illegal; sampled with start
key  in  256  cipher key, MSB-justified: AES-128 uses key[255:128], AES-192 uses key[255:64]; w0 = key[255:224]
busy  out  1  high in LOAD/GEN
key_expanded  out  1  one-cycle pulse on entry to DONE
keys_valid  out  1  high in DONE until next accepted start or reset
err  out  1  one-cycle pulse when start is accepted with illegal key_len
rd_round  in  4  round-key index 0..Nr
rd_key  out  128  words 4r..4r+3 of the store, w[4r] in [127:96]; combinational

Behaviour:
- Reset: state IDLE. busy, key_expanded, keys_valid and err are 0. Store, window, Rcon, Nk_reg, Nr_reg and word counter i are 0. rd_key reads 0.
- Nk/Nr: key_len 0 gives 4/10, 1 gives 6/12, 2 gives 8/14. Total words = 4*(Nr+1), i.e. 44, 52 or 60.
- States: IDLE, LOAD, GEN, DONE.
- IDLE/DONE with start=1:
  - Illegal key_len: pulse err, stay in the current state with contents unchanged.
  - Legal key_len: latch Nk/Nr and key, clear keys_valid, go to LOAD.
- LOAD (1 cycle): write w[0..Nk-1] from key into the store and into an 8-word sliding window. Set i=Nk and rcon=8'h01. Go to GEN.
- GEN (one word per cycle):
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp. Write it to store[i], shift the window, i <= i+1.
  - Use a modulo counter for i mod Nk, not a divider.
  - When i == total-1 is written, go to DONE.
- GEN latency: 40, 46 or 52 cycles. start→key_expanded = 1 + 1 + gen cycles: 42 (AES-128), 48 (AES-192), 54 (AES-256).
- DONE: key_expanded high for the first cycle only. keys_valid is held. An accepted start restarts expansion; otherwise remain in DONE.
- start while busy: ignored, no err, no effect.
- rd_key:
  - Valid only while keys_valid=1.
  - rd_round > Nr_reg returns 128'h0.
  - Reads during GEN return partially written data and are not defined for consumers.
- SubWord: 4 combinational byte S-boxes, shared between the RotWord and plain SubWord paths. No other substitution logic.
- Reset mid-operation: immediate return to reset values. A subsequent start behaves as from power-up.
- Store is not cleared on restart. Words beyond the new total keep stale values but are masked by the rd_round > Nr rule.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c: key_expanded exactly 42 cycles after start. rd_round=1 gives a0fafe1788542cb123a339392a6c7605. rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: done at 48 cycles. rd_round=12 gives e98ba06f448c773c8ecc720401002202. rd_round=13 gives 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: done at 54 cycles. rd_round=14 gives fe4890d1e6188d0b046df344706c631e. This exercises the i mod 8 == 4 SubWord path.
- key_len=3 with start in IDLE: err pulses 1 cycle, busy stays 0. Repeat in DONE after an AES-128 run: keys_valid stays 1 and rd_round=10 is unchanged.
- Second start pulses during GEN are ignored and done timing is unchanged. After DONE, an AES-128 run followed by an AES-256 run gives the correct round-14 key. n_rst asserted at GEN cycle 20 clears all outputs within the same cycle; a following AES-128 run matches scenario 1.
